mp3_sdi_feeder: RTL and testbench



---
 rtl/mp3_sdi_pkg.sv | 22 ++
 rtl/mp3_sdi_feeder_byte_tx.sv | 66 ++++++
 rtl/mp3_sdi_feeder.sv | 107 ++++++++++
 tb/tb_mp3_sdi_feeder.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_sdi_pkg.sv
// Shared definitions for the MP3 SDI feeder: FSM encoding, pin idle levels
// and a small width helper.
package mp3_sdi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_POP   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_SHIFT = 3'd3,
      ST_GAP   = 3'd4
   } state_t;

   localparam logic SDI_IDLE_SCK      = 1'b0;
   localparam logic XDCS_INACTIVE     = 1'b1;
   localparam int   DEFAULT_BURST_LEN = 32;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int bits_for(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mp3_sdi_feeder_byte_tx.sv
// Shifts one byte out MSB first on SCK/MOSI; SCK idles low and each level
// lasts CLK_DIV clocks. done is high in the last clock of bit 0's high phase.
module sdi_byte_tx
   import mp3_sdi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       sck,
   output logic       mosi,
   output logic       done
);

   localparam int               DIV_W    = bits_for(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic             active;
   logic [DIV_W-1:0] div_cnt;
   logic [2:0]       bit_cnt;
   logic [6:0]       shreg;
   logic             phase_end;

   assign phase_end = active && (div_cnt == DIV_LAST);
   assign done      = phase_end && sck && (bit_cnt == 3'd0);

   // MOSI only moves as SCK returns low, so it is stable across every rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active  <= 1'b0;
         sck     <= SDI_IDLE_SCK;
         mosi    <= 1'b0;
         div_cnt <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (load) begin
         active  <= 1'b1;
         sck     <= SDI_IDLE_SCK;
         mosi    <= data[7];
         shreg   <= data[6:0];
         bit_cnt <= 3'd7;
         div_cnt <= '0;
      end else if (active) begin
         if (phase_end) begin
            div_cnt <= '0;
            if (!sck) begin
               sck <= 1'b1;
            end else begin
               sck <= SDI_IDLE_SCK;
               if (bit_cnt == 3'd0) begin
                  active <= 1'b0;
               end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  mosi    <= shreg[6];
                  shreg   <= {shreg[5:0], 1'b0};
               end
            end
         end else begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/mp3_sdi_feeder.sv
// Drains the MP3 byte FIFO into the decoder SDI port in DREQ-qualified bursts
// of up to BURST_LEN bytes, framing each burst with XDCS.
module mp3_sdi_feeder
   import mp3_sdi_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = DEFAULT_BURST_LEN,
   parameter int CLK_DIV    = 4,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   input  logic                  dreq,
   output logic                  sdi_sck,
   output logic                  sdi_mosi,
   output logic                  sdi_xdcs,
   output logic                  busy,
   output logic                  starved,
   output logic [CNT_WIDTH-1:0]  bytes_sent
);

   localparam int                 BURST_W    = bits_for(BURST_LEN);
   localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(BURST_LEN - 1);
   localparam int                 GAP_W      = bits_for(CLK_DIV - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(CLK_DIV - 1);

   state_t             state;
   logic [BURST_W-1:0] burst_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic               tx_load;
   logic               tx_done;

   // FIFO handshake: fifo_empty low is "valid", fifo_rd_en is "ready"; a read
   // happens only when both are high in POP, and fifo_data is used in LOAD.
   assign fifo_rd_en = (state == ST_POP) && !fifo_empty;
   assign tx_load    = (state == ST_LOAD);
   assign busy       = (state != ST_IDLE);

   sdi_byte_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_byte_tx (
      .clk  (clk),
      .rst  (rst),
      .load (tx_load),
      .data (fifo_data),
      .sck  (sdi_sck),
      .mosi (sdi_mosi),
      .done (tx_done)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sdi_xdcs   <= XDCS_INACTIVE;
         burst_cnt  <= '0;
         gap_cnt    <= '0;
         starved    <= 1'b0;
         bytes_sent <= '0;
      end else begin
         starved <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable && dreq && !fifo_empty) begin
                  sdi_xdcs  <= ~XDCS_INACTIVE;
                  burst_cnt <= '0;
                  state     <= ST_POP;
               end
            end
            ST_POP: begin
               if (!fifo_empty) begin
                  state <= ST_LOAD;
               end else begin
                  starved  <= 1'b1;
                  sdi_xdcs <= XDCS_INACTIVE;
                  gap_cnt  <= '0;
                  state    <= ST_GAP;
               end
            end
            ST_LOAD: state <= ST_SHIFT;
            ST_SHIFT: begin
               if (tx_done) begin
                  bytes_sent <= bytes_sent + CNT_WIDTH'(1);
                  burst_cnt  <= burst_cnt + BURST_W'(1);
                  // An empty FIFO at a byte boundary is a clean end of stream.
                  if ((burst_cnt == BURST_LAST) || !enable || fifo_empty) begin
                     sdi_xdcs <= XDCS_INACTIVE;
                     gap_cnt  <= '0;
                     state    <= ST_GAP;
                  end else begin
                     state <= ST_POP;
                  end
               end
            end
            ST_GAP: begin
               if (gap_cnt == GAP_LAST) state <= ST_IDLE;
               else gap_cnt <= gap_cnt + GAP_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mp3_sdi_feeder.sv
// Self-checking bench for mp3_sdi_feeder: FIFO model, SDI monitor with an
// expected-byte scoreboard, and one task per scenario.
module tb_mp3_sdi_feeder;

   localparam int CLK_DIV   = 4;
   localparam int BURST_LEN = 32;
   localparam int CNT_WIDTH = 32;
   localparam int BYTE_CYC  = 2 + 16 * CLK_DIV;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 enable = 1'b0;
   logic                 dreq = 1'b0;
   logic                 force_empty = 1'b0;
   logic                 fifo_empty;
   logic [7:0]           fifo_data;
   logic                 fifo_rd_en;
   logic                 sdi_sck, sdi_mosi, sdi_xdcs, busy, starved;
   logic [CNT_WIDTH-1:0] bytes_sent;

   int         compared = 0;
   int         mismatched = 0;
   int         exp_sent = 0;
   logic [7:0] exp_q[$];
   int         burst_q[$];

   logic [7:0] fifo_mem [0:1023];
   int         wr_ptr = 0;
   int         rd_ptr = 0;

   int         rd_cnt = 0, starve_cnt = 0;
   logic       mon_prev_sck = 1'b0, mon_prev_xdcs = 1'b1, mon_seen_burst = 1'b0;
   int         mon_bit_n = 0, mon_run = 0, mon_hi_run = 0, mon_burst_bytes = 0;
   logic [7:0] mon_sh = 8'h00;

   mp3_sdi_feeder #(
      .DATA_WIDTH (8),
      .BURST_LEN  (BURST_LEN),
      .CLK_DIV    (CLK_DIV),
      .CNT_WIDTH  (CNT_WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .dreq       (dreq),
      .sdi_sck    (sdi_sck),
      .sdi_mosi   (sdi_mosi),
      .sdi_xdcs   (sdi_xdcs),
      .busy       (busy),
      .starved    (starved),
      .bytes_sent (bytes_sent)
   );

   // ---------------- clock / FIFO model ----------------
   always #5 clk = ~clk;

   assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr    <= wr_ptr;
         fifo_data <= 8'h00;
      end else if (fifo_rd_en) begin
         fifo_data <= fifo_mem[rd_ptr];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // ---------------- SDI monitor + scoreboard ----------------
   always @(negedge clk) begin
      logic [7:0] exp_b;
      #2;
      if (rst) begin
         mon_prev_sck = 1'b0; mon_prev_xdcs = 1'b1; mon_seen_burst = 1'b0;
         mon_bit_n = 0; mon_run = 0; mon_hi_run = 0; mon_burst_bytes = 0; mon_sh = 8'h00;
      end else begin
         if (fifo_rd_en) begin
            rd_cnt++;
            compared++;
            if (fifo_empty) begin
               mismatched++;
               $display("FAIL rd_en_while_empty: rd_en=1 with fifo_empty=1 required no read at %0t", $time);
            end
         end
         if (starved) starve_cnt++;
         if (sdi_sck != mon_prev_sck) begin
            if (mon_prev_sck || mon_bit_n != 0) begin
               compared++;
               if (mon_run != CLK_DIV) begin
                  mismatched++;
                  $display("FAIL sck_level_len: level %0b lasted %0d clocks required %0d", mon_prev_sck, mon_run, CLK_DIV);
               end
            end
            mon_run = 1;
         end else begin
            mon_run++;
         end
         if (sdi_sck && !mon_prev_sck) begin
            compared++;
            if (sdi_xdcs !== 1'b0) begin
               mismatched++;
               $display("FAIL sck_without_cs: xdcs=%0b required 0 on SCK rise", sdi_xdcs);
            end
            mon_sh = {mon_sh[6:0], sdi_mosi};
            mon_bit_n++;
            if (mon_bit_n == 8) begin
               mon_bit_n = 0;
               mon_burst_bytes++;
               compared++;
               if (exp_q.size() == 0) begin
                  mismatched++;
                  $display("FAIL sb_underflow: got byte %02h required none", mon_sh);
               end else begin
                  exp_b = exp_q.pop_front();
                  if (mon_sh !== exp_b) begin
                     mismatched++;
                     $display("FAIL sb_byte: got %02h required %02h", mon_sh, exp_b);
                  end
               end
            end
         end
         if (sdi_xdcs && !mon_prev_xdcs) begin
            burst_q.push_back(mon_burst_bytes);
            mon_burst_bytes = 0;
            mon_hi_run = 1;
            mon_seen_burst = 1'b1;
         end else if (sdi_xdcs) begin
            mon_hi_run++;
         end else if (mon_prev_xdcs && mon_seen_burst) begin
            compared++;
            if (mon_hi_run < CLK_DIV) begin
               mismatched++;
               $display("FAIL xdcs_gap: high %0d clocks required >= %0d", mon_hi_run, CLK_DIV);
            end
         end
         mon_prev_sck = sdi_sck;
         mon_prev_xdcs = sdi_xdcs;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_byte(input logic [7:0] b);
      fifo_mem[wr_ptr] = b;
      wr_ptr = wr_ptr + 1;
      exp_q.push_back(b);
   endtask

   task automatic wait_bytes(input int target, input int budget, input string name);
      int n = 0;
      while (bytes_sent != CNT_WIDTH'(target) && n < budget) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (bytes_sent != CNT_WIDTH'(target)) begin
         mismatched++;
         $display("FAIL %s: bytes_sent=%0d required %0d within %0d cycles", name, bytes_sent, target, budget);
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while (busy && n < budget) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (busy) begin
         mismatched++;
         $display("FAIL %s: busy=1 required 0 within %0d cycles", name, budget);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; dreq = 1'b0; force_empty = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      compared += 7;
      if (sdi_sck !== 1'b0)  begin mismatched++; $display("FAIL reset_sck: got %0b required 0", sdi_sck); end
      if (sdi_mosi !== 1'b0) begin mismatched++; $display("FAIL reset_mosi: got %0b required 0", sdi_mosi); end
      if (sdi_xdcs !== 1'b1) begin mismatched++; $display("FAIL reset_xdcs: got %0b required 1", sdi_xdcs); end
      if (busy !== 1'b0)     begin mismatched++; $display("FAIL reset_busy: got %0b required 0", busy); end
      if (starved !== 1'b0)  begin mismatched++; $display("FAIL reset_starved: got %0b required 0", starved); end
      if (fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en: got %0b required 0", fifo_rd_en); end
      if (bytes_sent !== '0) begin mismatched++; $display("FAIL reset_bytes: got %0d required 0", bytes_sent); end
   endtask

   task automatic test_single_byte();
      int r0 = rd_cnt;
      int s0 = starve_cnt;
      int gap = 0;
      burst_q.delete();
      enable = 1'b1; dreq = 1'b1;
      push_byte(8'hA5);
      exp_sent = 1;
      wait_bytes(exp_sent, 2 * BYTE_CYC, "single_done");
      compared += 2;
      if (sdi_xdcs !== 1'b1) begin mismatched++; $display("FAIL single_xdcs_rise: got %0b required 1", sdi_xdcs); end
      if (sdi_sck !== 1'b0)  begin mismatched++; $display("FAIL single_sck_low: got %0b required 0", sdi_sck); end
      while (busy && gap < 50) begin gap++; @(negedge clk); end
      compared++;
      if (gap != CLK_DIV) begin mismatched++; $display("FAIL single_gap_len: got %0d required %0d", gap, CLK_DIV); end
      repeat (3) @(negedge clk);
      compared += 4;
      if (rd_cnt - r0 != 1)     begin mismatched++; $display("FAIL single_rd_pulses: got %0d required 1", rd_cnt - r0); end
      if (starve_cnt != s0)     begin mismatched++; $display("FAIL single_starved: got %0d pulses required 0", starve_cnt - s0); end
      if (bytes_sent !== 32'd1) begin mismatched++; $display("FAIL single_bytes: got %0d required 1", bytes_sent); end
      if (burst_q.size() != 1 || burst_q[0] != 1) begin
         mismatched++; $display("FAIL single_burst: got %0d bursts required one of 1 byte", burst_q.size());
      end
   endtask

   task automatic test_burst_40();
      int r0 = rd_cnt;
      burst_q.delete();
      for (int i = 0; i < 40; i++) push_byte(8'($urandom_range(0, 255)));
      exp_sent += 40;
      wait_bytes(exp_sent, 40 * BYTE_CYC + 100, "burst40_done");
      wait_idle(50, "burst40_idle");
      repeat (3) @(negedge clk);
      compared += 4;
      if (burst_q.size() != 2) begin mismatched++; $display("FAIL burst40_count: got %0d bursts required 2", burst_q.size()); end
      if (burst_q[0] != BURST_LEN) begin mismatched++; $display("FAIL burst40_first: got %0d required %0d", burst_q[0], BURST_LEN); end
      if (burst_q[1] != 8) begin mismatched++; $display("FAIL burst40_second: got %0d required 8", burst_q[1]); end
      if (rd_cnt - r0 != 40) begin mismatched++; $display("FAIL burst40_rd_pulses: got %0d required 40", rd_cnt - r0); end
   endtask

   task automatic test_dreq_low();
      int r0 = rd_cnt;
      int bad = 0;
      dreq = 1'b0;
      for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
      repeat (1000) begin
         @(negedge clk);
         if (sdi_sck || !sdi_xdcs || busy) bad++;
      end
      compared += 2;
      if (bad != 0) begin mismatched++; $display("FAIL dreq_low_quiet: got %0d active cycles required 0", bad); end
      if (rd_cnt != r0) begin mismatched++; $display("FAIL dreq_low_rd: got %0d reads required 0", rd_cnt - r0); end
      burst_q.delete();
      for (int i = 0; i < 35; i++) push_byte(8'($urandom_range(0, 255)));
      dreq = 1'b1;
      wait_bytes(exp_sent + 3, 4 * BYTE_CYC + 20, "dreq_third_byte");
      dreq = 1'b0;
      exp_sent += BURST_LEN;
      wait_bytes(exp_sent, BURST_LEN * BYTE_CYC + 20, "dreq_drop_burst");
      wait_idle(50, "dreq_drop_idle");
      repeat (20) @(negedge clk);
      compared += 2;
      if (bytes_sent !== CNT_WIDTH'(exp_sent)) begin mismatched++; $display("FAIL dreq_drop_total: got %0d required %0d", bytes_sent, exp_sent); end
      if (burst_q.size() != 1 || burst_q[0] != BURST_LEN) begin
         mismatched++; $display("FAIL dreq_drop_burst_len: got %0d bursts required one of %0d", burst_q.size(), BURST_LEN);
      end
   endtask

   task automatic test_enable_drop();
      int n = 0;
      burst_q.delete();
      enable = 1'b1; dreq = 1'b1;
      wait_bytes(exp_sent + 1, 2 * BYTE_CYC, "enable_first_byte");
      while (mon_bit_n != 4 && n < 200) begin @(negedge clk); n++; end
      compared++;
      if (mon_bit_n != 4) begin mismatched++; $display("FAIL enable_bit4: got bit %0d required 4", mon_bit_n); end
      enable = 1'b0;
      wait_idle(3 * BYTE_CYC, "enable_drop_idle");
      exp_sent += 2;
      compared += 2;
      if (bytes_sent !== CNT_WIDTH'(exp_sent)) begin mismatched++; $display("FAIL enable_drop_count: got %0d required %0d", bytes_sent, exp_sent); end
      if (sdi_xdcs !== 1'b1) begin mismatched++; $display("FAIL enable_drop_xdcs: got %0b required 1", sdi_xdcs); end
      repeat (50) @(negedge clk);
      compared += 2;
      if (bytes_sent !== CNT_WIDTH'(exp_sent)) begin mismatched++; $display("FAIL enable_hold_count: got %0d required %0d", bytes_sent, exp_sent); end
      if (busy !== 1'b0) begin mismatched++; $display("FAIL enable_hold_busy: got %0b required 0", busy); end
      enable = 1'b1;
      exp_sent += 6;
      wait_bytes(exp_sent, 6 * BYTE_CYC + 50, "enable_resume");
      wait_idle(50, "enable_resume_idle");
      repeat (3) @(negedge clk);
      compared++;
      if (burst_q.size() != 2 || burst_q[0] != 2 || burst_q[1] != 6) begin
         mismatched++; $display("FAIL enable_bursts: got %0d bursts required 2 then 6 bytes", burst_q.size());
      end
   endtask

   task automatic test_starvation();
      int base = exp_sent;
      int s0 = starve_cnt;
      int r0 = rd_cnt;
      for (int i = 0; i < 10; i++) push_byte(8'($urandom_range(0, 255)));
      wait_bytes(base + 5, 6 * BYTE_CYC + 20, "starve_fifth");
      force_empty = 1'b1;
      #1;
      compared++;
      if (fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL starve_no_rd: got %0b required 0", fifo_rd_en); end
      @(negedge clk);
      compared += 2;
      if (starved !== 1'b1)  begin mismatched++; $display("FAIL starve_pulse: got %0b required 1", starved); end
      if (sdi_xdcs !== 1'b1) begin mismatched++; $display("FAIL starve_xdcs: got %0b required 1", sdi_xdcs); end
      wait_idle(50, "starve_idle");
      repeat (5) @(negedge clk);
      compared += 3;
      if (starve_cnt - s0 != 1) begin mismatched++; $display("FAIL starve_once: got %0d pulses required 1", starve_cnt - s0); end
      if (bytes_sent !== CNT_WIDTH'(base + 5)) begin mismatched++; $display("FAIL starve_bytes: got %0d required %0d", bytes_sent, base + 5); end
      if (rd_cnt - r0 != 5) begin mismatched++; $display("FAIL starve_rd_pulses: got %0d required 5", rd_cnt - r0); end
      force_empty = 1'b0;
      exp_sent = base + 10;
      wait_bytes(exp_sent, 6 * BYTE_CYC + 50, "starve_resume");
      wait_idle(50, "starve_resume_idle");
      compared++;
      if (starve_cnt - s0 != 1) begin mismatched++; $display("FAIL starve_end_of_stream: got %0d pulses required 1", starve_cnt - s0); end
   endtask

   task automatic test_reset_mid_shift();
      int n = 0;
      int r0;
      for (int i = 0; i < 4; i++) push_byte(8'($urandom_range(0, 255)));
      while (!sdi_sck && n < 200) begin @(negedge clk); n++; end
      compared++;
      if (sdi_sck !== 1'b1) begin mismatched++; $display("FAIL rst_pre_sck: got %0b required 1", sdi_sck); end
      #1 rst = 1'b1;
      #1;
      compared += 3;
      if (sdi_xdcs !== 1'b1)  begin mismatched++; $display("FAIL rst_async_xdcs: got %0b required 1", sdi_xdcs); end
      if (sdi_sck !== 1'b0)   begin mismatched++; $display("FAIL rst_async_sck: got %0b required 0", sdi_sck); end
      if (bytes_sent !== '0)  begin mismatched++; $display("FAIL rst_async_bytes: got %0d required 0", bytes_sent); end
      exp_q.delete();
      exp_sent = 0;
      dreq = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      r0 = rd_cnt;
      push_byte(8'h3C);
      push_byte(8'hC3);
      repeat (30) @(negedge clk);
      compared += 4;
      if (rd_cnt != r0)      begin mismatched++; $display("FAIL rst_no_rd: got %0d reads required 0", rd_cnt - r0); end
      if (sdi_xdcs !== 1'b1) begin mismatched++; $display("FAIL rst_idle_xdcs: got %0b required 1", sdi_xdcs); end
      if (busy !== 1'b0)     begin mismatched++; $display("FAIL rst_idle_busy: got %0b required 0", busy); end
      if (sdi_mosi !== 1'b0) begin mismatched++; $display("FAIL rst_idle_mosi: got %0b required 0", sdi_mosi); end
      dreq = 1'b1;
      exp_sent = 2;
      wait_bytes(exp_sent, 3 * BYTE_CYC, "rst_requalify");
      wait_idle(50, "rst_requalify_idle");
      repeat (3) @(negedge clk);
      compared++;
      if (exp_q.size() != 0) begin mismatched++; $display("FAIL sb_drained: %0d bytes left required 0", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_burst_40();
      test_dreq_low();
      test_enable_drop();
      test_starvation();
      test_reset_mid_shift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
